// File: rtl/obj_pkg.sv
`default_nettype none
// ============================================================================
// obj_pkg : shared state encoding and constants for the OBJ pixel fetcher
// Revision: 1.0
// ============================================================================
package obj_pkg;

    localparam int SCREEN_W    = 240;
    localparam int OBJ_VRAM_AW = 15;
    localparam int OBJ_XW      = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } obj_fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/obj_pixel_unpack.sv
`default_nettype none
// ============================================================================
// obj_pixel_unpack : selects pixel k of a VRAM halfword and forms its palette index
// Revision: 1.0
// ============================================================================
module obj_pixel_unpack
    import obj_pkg::*;
(
    input  logic [15:0] rdata,
    input  logic [1:0]  k,
    input  logic        palettemode,
    input  logic [3:0]  palbank,
    output logic [7:0]  lb_color,
    output logic        opaque
);

    logic [3:0] nibble;
    logic [7:0] byte_sel;

    always_comb begin
        nibble = rdata[3:0];
        case (k)
            2'd0:    nibble = rdata[3:0];
            2'd1:    nibble = rdata[7:4];
            2'd2:    nibble = rdata[11:8];
            default: nibble = rdata[15:12];
        endcase
        byte_sel = k[0] ? rdata[15:8] : rdata[7:0];
    end

    // Transparency is decided on the raw texel, before the palette bank is merged in.
    assign lb_color = palettemode ? byte_sel : {palbank, nibble};
    assign opaque   = palettemode ? (byte_sel != 8'd0) : (nibble != 4'd0);

endmodule
`default_nettype wire

// File: rtl/obj_pixel_fetcher.sv
`default_nettype none
// ============================================================================
// obj_pixel_fetcher : walks one sprite line, fetches OBJ VRAM halfwords and
//                     writes visible opaque pixels into the OBJ line buffer
// Revision: 1.0
// ============================================================================
module obj_pixel_fetcher #(
    parameter int SCREEN_W = obj_pkg::SCREEN_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  obj_x,
    input  logic [6:0]  obj_width,
    input  logic [5:0]  row,
    input  logic        hflip,
    input  logic        palettemode,
    input  logic [3:0]  palbank,
    input  logic [1:0]  obj_pri,
    output logic        busy,
    output logic        done,
    output logic [5:0]  au_x,
    output logic [5:0]  au_y,
    input  logic [14:0] au_addr,
    output logic        vram_req,
    output logic [14:0] vram_addr,
    input  logic        vram_gnt,
    input  logic        vram_rvalid,
    input  logic [15:0] vram_rdata,
    output logic        lb_we,
    output logic [7:0]  lb_x,
    output logic [7:0]  lb_color,
    output logic [1:0]  lb_pri
);

    import obj_pkg::*;

    localparam logic [OBJ_XW-1:0] SCREEN_W_X = OBJ_XW'(SCREEN_W);

    obj_fetch_state_t state, state_nxt;

    logic [8:0]  x_q;
    logic [6:0]  width_q;
    logic [5:0]  row_q;
    logic        hflip_q;
    logic        mode_q;
    logic [3:0]  bank_q;
    logic [1:0]  pri_q;
    logic [6:0]  col_q;
    logic [1:0]  k_q;
    logic [15:0] data_q;

    logic [6:0]  ppw;
    logic [1:0]  k_last;
    logic [6:0]  col_step;
    logic        last_pixel;
    logic        last_word;
    logic [6:0]  texel;
    logic [8:0]  sx;
    logic [7:0]  pix_color;
    logic        opaque;
    logic        unused_addr_lsb;

    assign ppw        = mode_q ? 7'd2 : 7'd4;
    assign k_last     = mode_q ? 2'd1 : 2'd3;
    assign last_pixel = (k_q == k_last);
    assign col_step   = col_q + ppw;
    assign last_word  = (col_step == width_q);
    assign texel      = col_q + {5'd0, k_q};

    // 9-bit arithmetic wraps mod 512, so negative sprite offsets land at high x and get clipped.
    assign sx = hflip_q ? (x_q + {2'b00, width_q} - 9'd1 - {2'b00, texel})
                        : (x_q + {2'b00, texel});

    obj_pixel_unpack u_unpack (
        .rdata       (data_q),
        .k           (k_q),
        .palettemode (mode_q),
        .palbank     (bank_q),
        .lb_color    (pix_color),
        .opaque      (opaque)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        vram_req  = 1'b0;
        lb_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (obj_width == 7'd0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                busy     = 1'b1;
                vram_req = 1'b1;
                if (vram_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (vram_rvalid) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy  = 1'b1;
                lb_we = opaque && (sx < SCREEN_W_X);
                if (last_pixel) begin
                    state_nxt = last_word ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q     <= '0;
            width_q <= '0;
            row_q   <= '0;
            hflip_q <= 1'b0;
            mode_q  <= 1'b0;
            bank_q  <= '0;
            pri_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_q     <= obj_x;
                        width_q <= obj_width;
                        row_q   <= row;
                        hflip_q <= hflip;
                        mode_q  <= palettemode;
                        bank_q  <= palbank;
                        pri_q   <= obj_pri;
                        col_q   <= '0;
                        k_q     <= '0;
                    end
                end
                ST_WAIT: begin
                    if (vram_rvalid) begin
                        data_q <= vram_rdata;
                        k_q    <= '0;
                    end
                end
                ST_EMIT: begin
                    if (last_pixel) begin
                        k_q   <= '0;
                        col_q <= col_step;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte address from the address unit is forced to halfword alignment.
    assign unused_addr_lsb = au_addr[0];
    assign vram_addr = vram_req ? {au_addr[14:1], 1'b0} : 15'd0;
    assign au_x      = col_q[5:0];
    assign au_y      = row_q;
    assign lb_pri    = pri_q;
    assign lb_x      = (state == ST_EMIT) ? sx[7:0] : 8'd0;
    assign lb_color  = (state == ST_EMIT) ? pix_color : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_obj_pixel_fetcher.sv
`default_nettype none
// ============================================================================
// tb_obj_pixel_fetcher : scoreboard bench with a VRAM responder and a texel-level
//                        reference model of the sprite line
// Revision: 1.0
// ============================================================================
module tb_obj_pixel_fetcher;
    import obj_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [8:0]  obj_x;
    logic [6:0]  obj_width;
    logic [5:0]  row;
    logic        hflip, palettemode;
    logic [3:0]  palbank;
    logic [1:0]  obj_pri;
    logic        busy, done, vram_req, vram_gnt, vram_rvalid, lb_we;
    logic [5:0]  au_x, au_y;
    logic [14:0] au_addr, vram_addr;
    logic [15:0] vram_rdata;
    logic [7:0]  lb_x, lb_color;
    logic [1:0]  lb_pri;
    logic        addr_lsb = 1'b0;

    always #5 clock = ~clock;

    // Address unit stand-in: unique address per (row, column) with a random low bit.
    assign au_addr = {2'b00, au_y, au_x, addr_lsb};

    obj_pixel_fetcher #(.SCREEN_W(240)) dut (
        .clock(clock), .reset(reset), .start(start), .obj_x(obj_x), .obj_width(obj_width),
        .row(row), .hflip(hflip), .palettemode(palettemode), .palbank(palbank), .obj_pri(obj_pri),
        .busy(busy), .done(done), .au_x(au_x), .au_y(au_y), .au_addr(au_addr),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_gnt(vram_gnt),
        .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata),
        .lb_we(lb_we), .lb_x(lb_x), .lb_color(lb_color), .lb_pri(lb_pri)
    );

    int checks = 0, passes = 0, fails = 0;
    logic [6:0]  exp_col_q[$];
    logic [15:0] data_q[$];
    logic [17:0] exp_wr_q[$];
    logic [15:0] words[32];
    logic [5:0]  cur_row = '0;
    int dones_expected = 0, done_seen = 0, gnt_count = 0;
    int gnt_hold = 0, rv_cnt = 0, hold_max = 0, rv_fixed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // VRAM responder: grants after a programmable hold, returns data after a delay.
    initial begin
        vram_gnt = 1'b0; vram_rvalid = 1'b0; vram_rdata = '0;
        forever begin
            @(negedge clock);
            vram_gnt = 1'b0; vram_rvalid = 1'b0; vram_rdata = '0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    vram_rvalid = 1'b1;
                    vram_rdata  = (data_q.size() > 0) ? data_q.pop_front() : 16'hdead;
                end
            end else if (vram_req) begin
                if (exp_col_q.size() == 0) chk("unexpected_req", vram_req, 1'b0);
                else chk("req_addr", vram_addr, {2'b00, cur_row, exp_col_q[0][5:0], 1'b0});
                if (gnt_hold > 0) begin
                    gnt_hold--;
                    if ($urandom_range(0, 1) == 1) begin
                        vram_rvalid = 1'b1;
                        vram_rdata  = 16'($urandom);
                    end
                end else begin
                    vram_gnt = 1'b1;
                    gnt_count++;
                    if (exp_col_q.size() > 0) void'(exp_col_q.pop_front());
                    rv_cnt   = (rv_fixed > 0) ? rv_fixed : $urandom_range(1, 4);
                    gnt_hold = $urandom_range(0, hold_max);
                end
            end
        end
    end

    // Monitor: line buffer writes and done pulses against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (lb_we) begin
                if (exp_wr_q.size() == 0) chk("unexpected_write", lb_we, 1'b0);
                else chk("write{x,color,pri}", {lb_x, lb_color, lb_pri}, exp_wr_q.pop_front());
            end
            if (done) begin
                if (dones_expected == 0) chk("unexpected_done", done, 1'b0);
                else begin
                    dones_expected--;
                    done_seen++;
                    chk("busy_during_done", busy, 1'b0);
                end
            end
        end
    end

    task automatic run_sprite(input logic [8:0] x, input logic [6:0] w, input bit hf, input bit pm,
                              input logic [3:0] pb, input logic [1:0] pri, input logic [5:0] rw,
                              input int first_hold);
        int ppw = pm ? 2 : 4;
        int base;
        int n;
        for (int i = 0; i < int'(w) / ppw; i++) begin
            exp_col_q.push_back(7'(i * ppw));
            data_q.push_back(words[i]);
        end
        for (int t = 0; t < int'(w); t++) begin
            int wd = int'(words[t / ppw]);
            int p  = pm ? ((wd >> (8 * (t % ppw))) & 255) : ((wd >> (4 * (t % ppw))) & 15);
            int sx = hf ? ((int'(x) + int'(w) - 1 - t) % 512) : ((int'(x) + t) % 512);
            logic [7:0] col = pm ? 8'(p) : {pb, 4'(p)};
            if (p != 0 && sx < 240) exp_wr_q.push_back({8'(sx), col, pri});
        end
        cur_row  = rw;
        gnt_hold = first_hold;
        dones_expected++;
        base = done_seen;
        @(negedge clock);
        addr_lsb = 1'($urandom_range(0, 1));
        obj_x = x; obj_width = w; hflip = hf; palettemode = pm;
        palbank = pb; obj_pri = pri; row = rw; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        obj_x = 9'($urandom); obj_width = 7'($urandom); row = 6'($urandom);
        if (w != 0) chk("first_req_busy", {busy, vram_req}, 2'b11);
        else begin
            if (!done) @(negedge clock);
            chk("zero_width_done", done, 1'b1);
        end
        n = 0;
        while (done_seen == base && n < 3000) begin
            @(negedge clock);
            n++;
            start = 1'b0;
            if (busy && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                obj_x = 9'($urandom); obj_width = 7'd8; hflip = 1'($urandom);
                palettemode = 1'($urandom); palbank = 4'($urandom); obj_pri = 2'($urandom);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("done_count", done_seen - base, 1);
        chk("writes_left", exp_wr_q.size(), 0);
        chk("reqs_left", exp_col_q.size(), 0);
    endtask

    task automatic reset_during_wait();
        int n = 0;
        int g = gnt_count;
        words[0] = 16'h1111;
        exp_col_q.push_back(7'd0);
        data_q.push_back(16'h1111);
        cur_row = 6'd9; rv_fixed = 6; gnt_hold = 0;
        @(negedge clock);
        obj_x = 9'd20; obj_width = 7'd8; row = 6'd9; hflip = 1'b0; palettemode = 1'b0;
        palbank = 4'd3; obj_pri = 2'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (gnt_count == g && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("rst_test_granted", gnt_count - g, 1);
        @(negedge clock);
        chk("rst_test_in_wait", {busy, vram_req}, 2'b10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_state_idle", dut.state, ST_IDLE);
        chk("rst_ctl", {busy, done, vram_req, lb_we}, 4'b0000);
        chk("rst_data", {au_x, au_y, vram_addr, lb_x, lb_color, lb_pri}, 45'd0);
        repeat (10) @(negedge clock);
        chk("rst_still_idle", {dut.state, busy}, {ST_IDLE, 1'b0});
        exp_col_q.delete();
        data_q.delete();
        rv_fixed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; obj_x = '0; obj_width = '0; row = '0;
        hflip = 1'b0; palettemode = 1'b0; palbank = '0; obj_pri = '0;
        repeat (3) @(negedge clock);
        chk("reset_ctl", {busy, done, vram_req, lb_we}, 4'b0000);
        chk("reset_data", {au_x, au_y, vram_addr, lb_x, lb_color, lb_pri}, 45'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed: 4bpp normal and flipped, 8bpp, clipping at both edges, grant stall.
        rv_fixed = 2; hold_max = 0;
        words[0] = 16'h3210; words[1] = 16'h7654;
        run_sprite(9'd10, 7'd8, 1'b0, 1'b0, 4'd5, 2'd2, 6'd3, 0);
        run_sprite(9'd10, 7'd8, 1'b1, 1'b0, 4'd5, 2'd1, 6'd3, 0);
        for (int i = 0; i < 4; i++) words[i] = 16'h0201;
        run_sprite(9'd0, 7'd8, 1'b0, 1'b1, 4'd0, 2'd0, 6'd7, 0);
        for (int i = 0; i < 4; i++)
            words[i] = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                        4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
        run_sprite(9'd500, 7'd16, 1'b0, 1'b0, 4'd9, 2'd3, 6'd1, 0);
        run_sprite(9'd236, 7'd16, 1'b0, 1'b0, 4'd9, 2'd3, 6'd1, 0);
        rv_fixed = 0;
        run_sprite(9'd40, 7'd16, 1'b0, 1'b1, 4'd0, 2'd2, 6'd12, 5);
        run_sprite(9'd40, 7'd0, 1'b0, 1'b0, 4'd0, 2'd2, 6'd12, 0);
        reset_during_wait();

        // Randomized sprites.
        hold_max = 3;
        for (int s = 0; s < 40; s++) begin
            logic [6:0] w;
            case ($urandom_range(0, 4))
                0: w = 7'd0;
                1: w = 7'd8;
                2: w = 7'd16;
                3: w = 7'd32;
                default: w = 7'd64;
            endcase
            for (int i = 0; i < 32; i++) words[i] = 16'($urandom) & 16'($urandom | 32'h5555);
            run_sprite(9'($urandom), w, 1'($urandom), 1'($urandom), 4'($urandom),
                       2'($urandom), 6'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
